// File: rtl/hazard_control_unit.sv
// Hazard control for the execute stage: operand forwarding selects, load-use
// stall/bubble, taken-branch flush, a fixed-latency multi-cycle freeze FSM and
// saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
  input  logic [NUM_SRC-1:0]            src_valid_d,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0]         rd_e,
  input  logic                          regwrite_e,
  input  logic                          isload_e,
  input  logic [REG_ADDR_W-1:0]         rd_m,
  input  logic                          regwrite_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          regwrite_w,
  input  logic                          branch_taken_e,
  input  logic                          mc_start_e,
  output logic [2*NUM_SRC-1:0]          forward_e,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          stall_e,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic                          mc_busy,
  output logic [CNT_W-1:0]              stall_count,
  output logic [CNT_W-1:0]              flush_count
);

  // Multi-cycle sequencing: the start cycle freezes combinationally, then
  // BUSY covers the remaining MC_LATENCY-2 frozen cycles.
  localparam bit          MC_EN    = (MC_LATENCY > 1);
  localparam bit          MC_HAS_B = (MC_LATENCY > 2);
  localparam int unsigned MC_LOAD  = MC_HAS_B ? (MC_LATENCY - 2) : 0;
  localparam int unsigned MC_W     = MC_HAS_B ? $clog2(MC_LATENCY) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q;
  logic [MC_W-1:0]   mc_cnt_q;
  logic [MC_W-1:0]   mc_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              busy;
  logic              load_use;
  logic              mc_go;

  assign busy     = (state_q == S_BUSY);
  assign mc_go    = MC_EN && !busy && mc_start_e && !branch_taken_e;
  assign mc_cnt_d = mc_cnt_q - MC_W'(1);

  // Per-operand forwarding select; the younger M-stage result wins over W.
  always_comb begin
    forward_e = '0;
    if (!rst) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (regwrite_m && (rd_m != '0) && (rd_m == rs_e[i*REG_ADDR_W +: REG_ADDR_W])) begin
          forward_e[2*i +: 2] = 2'b10;
        end else if (regwrite_w && (rd_w != '0) &&
                     (rd_w == rs_e[i*REG_ADDR_W +: REG_ADDR_W])) begin
          forward_e[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    load_use = 1'b0;
    if (isload_e && regwrite_e && (rd_e != '0)) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (src_valid_d[i] && (rs_d[i*REG_ADDR_W +: REG_ADDR_W] == rd_e)) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // Stall/flush decision, priority: reset > BUSY > branch > mc start > load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    mc_busy = 1'b0;
    if (!rst) begin
      if (busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        mc_busy = 1'b1;
      end else if (branch_taken_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (mc_go) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Multi-cycle FSM: count down the remaining BUSY cycles, leave when exhausted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mc_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mc_go && MC_HAS_B) begin
            mc_cnt_q <= MC_W'(MC_LOAD);
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          mc_cnt_q <= mc_cnt_d;
          if (mc_cnt_d == '0) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          mc_cnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters: stalled-fetch cycles and branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_d && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_control_unit;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic               clk;
  logic               rst;
  logic [NS*AW-1:0]   rs_d;
  logic [NS-1:0]      src_valid_d;
  logic [NS*AW-1:0]   rs_e;
  logic [AW-1:0]      rd_e;
  logic               regwrite_e;
  logic               isload_e;
  logic [AW-1:0]      rd_m;
  logic               regwrite_m;
  logic [AW-1:0]      rd_w;
  logic               regwrite_w;
  logic               branch_taken_e;
  logic               mc_start_e;
  logic [2*NS-1:0]    forward_e;
  logic               stall_f;
  logic               stall_d;
  logic               stall_e;
  logic               flush_d;
  logic               flush_e;
  logic               mc_busy;
  logic [CW-1:0]      stall_count;
  logic [CW-1:0]      flush_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  hazard_control_unit #(
    .REG_ADDR_W(AW), .NUM_SRC(NS), .MC_LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .src_valid_d(src_valid_d), .rs_e(rs_e),
    .rd_e(rd_e), .regwrite_e(regwrite_e), .isload_e(isload_e), .rd_m(rd_m),
    .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .branch_taken_e(branch_taken_e), .mc_start_e(mc_start_e),
    .forward_e(forward_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .mc_busy(mc_busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: frozen cycles left after the current one, and counts.
  int freeze_left = 0;
  int m_sc = 0;
  int m_fc = 0;
  logic [2*NS-1:0] e_fwd;
  bit e_sf, e_sd, e_se, e_fd, e_fe, e_busy, m_lu;

  // Compare process: judge the DUT mid-cycle, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_fwd = '0;
      {e_sf, e_sd, e_se, e_fd, e_fe, e_busy} = '0;
      m_lu = 1'b0;
      if (!rst) begin
        for (int i = 0; i < NS; i++) begin
          if (regwrite_m && rd_m != 0 && rd_m == rs_e[i*AW +: AW]) e_fwd[2*i +: 2] = 2'b10;
          else if (regwrite_w && rd_w != 0 && rd_w == rs_e[i*AW +: AW]) e_fwd[2*i +: 2] = 2'b01;
          if (isload_e && regwrite_e && rd_e != 0 && src_valid_d[i] && rs_d[i*AW +: AW] == rd_e)
            m_lu = 1'b1;
        end
        if (freeze_left > 0) begin
          e_sf = 1; e_sd = 1; e_se = 1; e_busy = 1;
        end else if (branch_taken_e) begin
          e_fd = 1; e_fe = 1;
        end else if (mc_start_e && LAT > 1) begin
          e_sf = 1; e_sd = 1; e_se = 1;
        end else if (m_lu) begin
          e_sf = 1; e_sd = 1; e_fe = 1;
        end
      end
      chk("model_forward_e", 32'(forward_e), 32'(e_fwd));
      chk("model_stall_f", 32'(stall_f), 32'(e_sf));
      chk("model_stall_d", 32'(stall_d), 32'(e_sd));
      chk("model_stall_e", 32'(stall_e), 32'(e_se));
      chk("model_flush_d", 32'(flush_d), 32'(e_fd));
      chk("model_flush_e", 32'(flush_e), 32'(e_fe));
      chk("model_mc_busy", 32'(mc_busy), 32'(e_busy));
      chk("model_stall_count", 32'(stall_count), 32'(m_sc));
      chk("model_flush_count", 32'(flush_count), 32'(m_fc));
      if (rst) begin
        freeze_left = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (freeze_left > 0) freeze_left--;
        else if (!branch_taken_e && mc_start_e && LAT > 1) freeze_left = LAT - 2;
        if (e_sf && m_sc < SAT) m_sc++;
        if (e_fd && m_fc < SAT) m_fc++;
      end
    end
  end

  task automatic idle_inputs();
    rs_d = '0; src_valid_d = '0; rs_e = '0; rd_e = '0; regwrite_e = 0; isload_e = 0;
    rd_m = '0; regwrite_m = 0; rd_w = '0; regwrite_w = 0; branch_taken_e = 0; mc_start_e = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1; idle_inputs();
    tick(); rst = 0;
  endtask

  task automatic lu_setup();
    isload_e = 1; regwrite_e = 1; rd_e = 5'd8;
    rs_d = {5'd8, 5'd0}; src_valid_d = 2'b10;
  endtask

  task automatic rand_inputs();
    rst            = ($urandom_range(0, 63) == 0);
    rs_d           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    src_valid_d    = 2'($urandom);
    rs_e           = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    rd_e           = 5'($urandom_range(0, 7));
    regwrite_e     = 1'($urandom);
    isload_e       = 1'($urandom);
    rd_m           = 5'($urandom_range(0, 7));
    regwrite_m     = 1'($urandom);
    rd_w           = 5'($urandom_range(0, 7));
    regwrite_w     = 1'($urandom);
    branch_taken_e = ($urandom_range(0, 7) == 0);
    mc_start_e     = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    // Reset with hazards and matches present on every input
    rst = 1; idle_inputs(); lu_setup(); branch_taken_e = 1; mc_start_e = 1;
    regwrite_m = 1; rd_m = 5'd5; rs_e = {5'd5, 5'd5};
    @(posedge clk); #1; chk_en = 1'b1;
    settle();
    chk("rst_stall_f", 32'(stall_f), 0);
    chk("rst_stall_e", 32'(stall_e), 0);
    chk("rst_flush_d", 32'(flush_d), 0);
    chk("rst_flush_e", 32'(flush_e), 0);
    chk("rst_forward", 32'(forward_e), 0);
    chk("rst_stall_count", 32'(stall_count), 0);

    // Forwarding: M beats W, then W when rd_m is x0
    tick(); rst = 0; idle_inputs();
    regwrite_m = 1; rd_m = 5'd5; regwrite_w = 1; rd_w = 5'd5; rs_e = {5'd7, 5'd5};
    settle(); chk("fwd_m_wins", 32'(forward_e), 32'h2);
    tick(); rd_m = 5'd0;
    settle(); chk("fwd_w_only", 32'(forward_e), 32'h1);

    // Load-use detection and its qualifiers
    tick(); idle_inputs(); lu_setup();
    settle();
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_flush_e", 32'(flush_e), 1);
    chk("lu_stall_e", 32'(stall_e), 0);
    chk("lu_count_before", 32'(stall_count), 0);
    tick(); src_valid_d = 2'b01;
    settle(); chk("lu_unread_src", 32'(stall_f), 0); chk("lu_count_after", 32'(stall_count), 1);
    tick(); src_valid_d = 2'b10; rd_e = 5'd0; rs_d = '0;
    settle(); chk("lu_rd_x0", 32'(stall_f), 0);

    // Branch overrides load-use
    do_reset(); lu_setup(); branch_taken_e = 1;
    settle();
    chk("br_flush_d", 32'(flush_d), 1);
    chk("br_flush_e", 32'(flush_e), 1);
    chk("br_stall_f", 32'(stall_f), 0);
    tick(); idle_inputs();
    settle(); chk("br_flush_count", 32'(flush_count), 1);

    // Multi-cycle op with hazards presented while frozen
    do_reset(); mc_start_e = 1;
    settle(); chk("mc_t_stall_e", 32'(stall_e), 1); chk("mc_t_busy", 32'(mc_busy), 0);
    tick(); mc_start_e = 0; lu_setup(); branch_taken_e = 1;
    settle();
    chk("mc_t1_busy", 32'(mc_busy), 1);
    chk("mc_t1_flush_d", 32'(flush_d), 0);
    chk("mc_t1_flush_e", 32'(flush_e), 0);
    tick(); idle_inputs();
    settle(); chk("mc_t2_stall_e", 32'(stall_e), 1); chk("mc_t2_busy", 32'(mc_busy), 1);
    tick();
    settle();
    chk("mc_t3_stall_e", 32'(stall_e), 0);
    chk("mc_t3_busy", 32'(mc_busy), 0);
    chk("mc_stall_count", 32'(stall_count), 3);

    // Reset in the middle of a multi-cycle op
    do_reset(); mc_start_e = 1;
    tick(); mc_start_e = 0; rst = 1;
    settle(); chk("mcrst_stall_e", 32'(stall_e), 0); chk("mcrst_busy", 32'(mc_busy), 0);
    tick(); rst = 0;
    settle();
    chk("mcrst_after_busy", 32'(mc_busy), 0);
    chk("mcrst_after_stall_f", 32'(stall_f), 0);
    chk("mcrst_after_count", 32'(stall_count), 0);

    // Stall counter saturation
    do_reset(); lu_setup();
    repeat (20) tick();
    settle(); chk("sat_stall_count", 32'(stall_count), 15);

    // Randomized traffic judged by the model
    do_reset();
    repeat (3000) begin
      tick(); rand_inputs();
    end
    tick(); idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
